el2_trace_buf: RTL
==================

# el2_trace_buf

Parametrised retirement-trace buffer between the decode/commit trace outputs and the external trace port. It accepts up to `NLANES` trace packets (`el2_trace_pkt_t`) per cycle and compacts valid lanes in lane order into a `DEPTH`-entry circular FIFO. It drains one packet per cycle under a valid/ready handshake. When space runs out it drops whole cycles of packets atomically, with a sticky overflow flag and a saturating drop counter.

## Interface
Parameters:
- `NLANES`, 2: retire lanes per cycle; legal values 1 or 2.
- `DEPTH`, 8: FIFO entries; power of two, 4..32.

Ports:
- `clk`, input, 1: core clock.
- `rst_l`, input, 1: reset. Asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `trace_in_pkt`, input, `NLANES` x `el2_trace_pkt_t` (104 b each): per-lane packet. `trace_rv_i_valid_ip` qualifies the lane.
- `trace_flush`, input, 1: synchronous empty of the FIFO.
- `ovf_clr`, input, 1: clears `trace_ovf` and `trace_drop_cnt`.
- `trace_out_pkt`, output, `el2_trace_pkt_t`: head entry. `trace_rv_i_valid_ip` = FIFO not empty.
- `trace_out_ready`, input, 1: consumer accepts the head this cycle.
- `trace_ovf`, output, 1: sticky overflow flag.
- `trace_drop_cnt`, output, 16: saturating count of dropped packets.
- `trace_count`, output, $clog2(DEPTH)+1: current occupancy.
- `trace_out_ts`, output, 32: head timestamp. Present only with `EL2_TRACE_TIMESTAMP_EN`.

## Operation
- `npush` = number of lanes with valid=1 (0..NLANES).
- Push is accepted iff `npush <= DEPTH - count`.
  - The same-cycle pop is not credited; this is deliberate, for timing.
- Accepted push: valid lanes are written in ascending lane index to `wrptr`, `wrptr+1`, …
  - Invalid lanes are skipped, so lane1 alone goes to `wrptr`.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Rejected push: no lane is written, even if a partial fit exists.
  - `trace_ovf` is set to 1.
  - `trace_drop_cnt += npush`, saturating at 0xFFFF.
- Pop: occurs when `trace_out_ready` is high and the FIFO is not empty. `rdptr` increments.
  - Ready while empty is ignored.
- `count_next = count + accepted_npush - pop`. Simultaneous push and pop are both legal.
- `trace_flush`: pointers and count go to 0, and that cycle's push and pop are discarded. `trace_ovf` and `trace_drop_cnt` are unaffected.
- `ovf_clr` combined with a drop in the same cycle:
  - `trace_ovf` = 1.
  - `trace_drop_cnt` = that cycle's `npush`, i.e. clear first, then add.
- Output packet fields are forced to 0 while the FIFO is empty.
- Storage array is not reset. Pointers, count, flag and counter are reset.

## Timing
- All outputs reset to 0: empty, valid=0, fields 0, `trace_ovf`=0, `trace_drop_cnt`=0, `trace_count`=0, `trace_out_ts`=0.
- Push at edge N: the packet is visible on `trace_out_pkt` after edge N when the FIFO was empty. Latency is 1 cycle; there is no combinational in→out path.
- `trace_out_pkt` is driven from the head register/array read only. `trace_out_ready` affects only next-state logic.
- Pop at edge N: the next entry is presented after edge N.
- Full (`count == DEPTH`): any valid lane drops, even if a pop occurs in the same cycle.
- Reset asserted mid-operation: all state clears asynchronously. Contents are lost and no partial state survives.
- Throughput is 1 packet/cycle out. Sustained 2-lane input overflows by design.

## Configuration
- `EL2_TRACE_TIMESTAMP_EN` defined:
  - A free-running 32-bit cycle counter runs from reset and wraps at 2^32.
  - Each entry stores the counter value of its push cycle. Both lanes of one push share a value.
  - `trace_out_ts` presents the head's stamp and is 0 when empty.
  - Flush does not reset the counter.
- Undefined: no counter, no timestamp storage, and no `trace_out_ts` port.

## Test plan
- NLANES=2, DEPTH=8, ready=0.
  - Push lane0 insn=0x00000013, lane1 insn=0x00100093 in cycle 1 -> count=2; out insn=0x00000013.
  - Then ready=1 for 2 cycles -> 0x00100093, then valid=0, count=0.
- Only lane1 valid (addr 0x80000004) -> stored at slot 0; out addr=0x80000004.
- DEPTH=4, ready=0, 3 entries stored, then a 2-lane push -> both dropped, count=3, `trace_ovf`=1, `drop_cnt`=2.
  - Then `ovf_clr` plus another 2-lane drop in the same cycle -> `drop_cnt`=2, `trace_ovf`=1.
- Wrap-around: DEPTH=4, 10 single pushes with concurrent pops and ready=1 -> output order matches input, no drops, pointers wrap twice.
- `trace_flush` with count=5 and a simultaneous push/pop -> count=0, output valid=0 next cycle; drop state unchanged.
- With `EL2_TRACE_TIMESTAMP_EN`: push 2 cycles after reset release -> `trace_out_ts`=2.
  - `rst_l` low mid-stream -> all outputs 0 immediately; ts restarts at 0.

Source files
------------

// File: rtl/el2_trace_buf.sv
// el2_trace_buf: retirement-trace FIFO, lane-compacting, atomic cycle drop.
// Optional head timestamps with EL2_TRACE_TIMESTAMP_EN.
package el2_trace_buf_pkg;
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;
endpackage

module el2_trace_buf
  import el2_trace_buf_pkg::*;
#(
  parameter int NLANES = 2,
  parameter int DEPTH  = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  el2_trace_pkt_t [NLANES-1:0]    trace_in_pkt,
  input  logic                           trace_flush,
  input  logic                           ovf_clr,
  output el2_trace_pkt_t                 trace_out_pkt,
  input  logic                           trace_out_ready,
  output logic                           trace_ovf,
  output logic [15:0]                    trace_drop_cnt,
  output logic [CW-1:0]                  trace_count
`ifdef EL2_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]                    trace_out_ts
`endif
);

  el2_trace_pkt_t r_mem [DEPTH];
  logic [PW-1:0]  r_wrptr;
  logic [PW-1:0]  r_rdptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic [15:0]    r_drop;

  logic [CW-1:0]  w_npush;
  logic [CW-1:0]  w_space;
  logic           w_empty;
  logic           w_fire;
  logic           w_acc;
  logic           w_drop;
  logic           w_pop;
  logic [PW-1:0]  w_off;
  logic [PW-1:0]  w_wslot [NLANES];
  logic           w_wen   [NLANES];
  logic [15:0]    w_drop_base;
  logic [16:0]    w_drop_sum;

  // Count valid lanes in this cycle's retire bundle.
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_npush = w_npush + CW'(trace_in_pkt[i].trace_rv_i_valid_ip);
    end
  end

  assign w_empty = (r_count == '0);
  assign w_space = CW'(DEPTH) - r_count;
  assign w_fire  = !trace_flush && (w_npush != '0);
  assign w_acc   = w_fire && (w_npush <= w_space);
  assign w_drop  = w_fire && !w_acc;
  assign w_pop   = !trace_flush && trace_out_ready && !w_empty;

  assign w_drop_base = ovf_clr ? 16'h0 : r_drop;
  assign w_drop_sum  = {1'b0, w_drop_base} + 17'(w_npush);

  // Compact valid lanes onto consecutive slots from the write pointer.
  always_comb begin
    w_off = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_wslot[i] = r_wrptr + w_off;
      w_wen[i]   = w_acc && trace_in_pkt[i].trace_rv_i_valid_ip;
      w_off      = w_off + PW'(trace_in_pkt[i].trace_rv_i_valid_ip);
    end
  end

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (w_wen[i]) r_mem[w_wslot[i]] <= trace_in_pkt[i];
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_count <= '0;
    end else if (trace_flush) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_wrptr <= r_wrptr + PW'(w_npush);
      if (w_pop) r_rdptr <= r_rdptr + PW'(1);
      r_count <= r_count + (w_acc ? w_npush : '0) - CW'(w_pop);
    end
  end

  // Sticky overflow and saturating drop count; clear applies before add.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ovf  <= w_drop ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);
      if (w_drop) r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      else        r_drop <= w_drop_base;
    end
  end

  // Head presentation, zeroed while empty.
  always_comb begin
    trace_out_pkt = '0;
    if (!w_empty) begin
      trace_out_pkt = r_mem[r_rdptr];
      trace_out_pkt.trace_rv_i_valid_ip = 1'b1;
    end
  end

  assign trace_ovf      = r_ovf;
  assign trace_drop_cnt = r_drop;
  assign trace_count    = r_count;

`ifdef EL2_TRACE_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_ts_mem [DEPTH];

  // Free-running cycle counter; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_ts <= '0;
    else        r_ts <= r_ts + 32'd1;
  end

  // One stamp per entry, shared by all lanes of a push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (w_wen[i]) r_ts_mem[w_wslot[i]] <= r_ts;
    end
  end

  assign trace_out_ts = w_empty ? 32'h0 : r_ts_mem[r_rdptr];
`endif

endmodule
